// File: rtl/apb_gpio_ext.sv
// APB GPIO controller: configurable pin count, atomic set/clear, sticky W1C interrupts.
// Define GPIO_DEBOUNCE_EN to build the per-pin debounce filter and DEBOUNCE register.
module apb_gpio_ext #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_GPIO       = 32,
    parameter int DEBOUNCE_W     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_GPIO-1:0]       gpio_in,
    output logic [NUM_GPIO-1:0]       gpio_in_sync,
    output logic [NUM_GPIO-1:0]       gpio_out,
    output logic [NUM_GPIO-1:0]       gpio_dir,
    output logic                      interrupt
);

    localparam logic [3:0] A_DIR       = 4'h0;
    localparam logic [3:0] A_IN        = 4'h1;
    localparam logic [3:0] A_OUT       = 4'h2;
    localparam logic [3:0] A_OUTSET    = 4'h3;
    localparam logic [3:0] A_OUTCLR    = 4'h4;
    localparam logic [3:0] A_INTEN     = 4'h5;
    localparam logic [3:0] A_INTTYPE0  = 4'h6;
    localparam logic [3:0] A_INTTYPE1  = 4'h7;
    localparam logic [3:0] A_INTSTATUS = 4'h8;
    localparam logic [3:0] A_DEBOUNCE  = 4'h9;

    logic [3:0]          addr;
    logic                acc;
    logic                wr_en;
    logic                mapped;
    logic [NUM_GPIO-1:0] wdata;
    logic [NUM_GPIO-1:0] dir_q, out_q, inten_q, type0_q, type1_q, status_q;
    logic [NUM_GPIO-1:0] sync0, sync1, filt, filt_d, cond, w1c;
    logic [31:0]         deb_rd;
    logic                unused_bits;

    function automatic logic [31:0] zext(input logic [NUM_GPIO-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_GPIO-1:0] = v;
        return r;
    endfunction

    assign addr   = PADDR[5:2];
    assign acc    = PSEL & PENABLE;
    assign wr_en  = acc & PWRITE;
    assign mapped = (addr <= A_DEBOUNCE);
    assign wdata  = PWDATA[NUM_GPIO-1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = acc & ~mapped;

    // Only PADDR[5:2] is decoded; upper data bits are dropped when NUM_GPIO < 32.
    assign unused_bits = ^{PADDR, PWDATA};

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dir_q   <= '0;
            out_q   <= '0;
            inten_q <= '0;
            type0_q <= '0;
            type1_q <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DIR:      dir_q   <= wdata;
                A_OUT:      out_q   <= wdata;
                A_OUTSET:   out_q   <= out_q | wdata;
                A_OUTCLR:   out_q   <= out_q & ~wdata;
                A_INTEN:    inten_q <= wdata;
                A_INTTYPE0: type0_q <= wdata;
                A_INTTYPE1: type1_q <= wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sync0  <= '0;
            sync1  <= '0;
            filt_d <= '0;
        end else begin
            sync0  <= gpio_in;
            sync1  <= sync0;
            filt_d <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEBOUNCE_W-1:0] deb_q;
    logic [DEBOUNCE_W-1:0] cnt [NUM_GPIO];
    logic [NUM_GPIO-1:0]   filt_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            deb_q <= '0;
        end else if (wr_en && addr == A_DEBOUNCE) begin
            deb_q <= PWDATA[DEBOUNCE_W-1:0];
        end
    end

    // A change is accepted after deb_q+1 consecutive samples that differ from filt.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_GPIO; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (sync1[i] == filt_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == deb_q) begin
                    filt_q[i] <= sync1[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    assign filt = filt_q;

    always_comb begin
        deb_rd = '0;
        deb_rd[DEBOUNCE_W-1:0] = deb_q;
    end
`else
    assign filt   = sync1;
    assign deb_rd = '0;
`endif

    always_comb begin
        cond = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            case ({type1_q[i], type0_q[i]})
                2'b00:   cond[i] = filt[i] & ~filt_d[i];
                2'b01:   cond[i] = ~filt[i] & filt_d[i];
                2'b10:   cond[i] = filt[i] ^ filt_d[i];
                default: cond[i] = filt[i];
            endcase
        end
    end

    assign w1c = (wr_en && addr == A_INTSTATUS) ? wdata : '0;

    // Set wins over a simultaneous clear so a held level cannot be acknowledged away.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c) | (cond & inten_q);
        end
    end

    always_comb begin
        PRDATA = '0;
        case (addr)
            A_DIR:       PRDATA = zext(dir_q);
            A_IN:        PRDATA = zext(filt);
            A_OUT:       PRDATA = zext(out_q);
            A_INTEN:     PRDATA = zext(inten_q);
            A_INTTYPE0:  PRDATA = zext(type0_q);
            A_INTTYPE1:  PRDATA = zext(type1_q);
            A_INTSTATUS: PRDATA = zext(status_q);
            A_DEBOUNCE:  PRDATA = deb_rd;
            default:     PRDATA = '0;
        endcase
    end

    assign gpio_in_sync = filt;
    assign gpio_out     = out_q;
    assign gpio_dir     = dir_q;
    assign interrupt    = |(status_q & inten_q);

endmodule

// File: tb/tb_apb_gpio_ext.sv
// Directed bench for apb_gpio_ext with NUM_GPIO=8; expectations follow GPIO_DEBOUNCE_EN.
module tb_apb_gpio_ext;

    localparam int NG = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [11:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE, PSEL, PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic [NG-1:0] gpio_in, gpio_in_sync, gpio_out, gpio_dir;
    logic          interrupt;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;
    logic        er;

    apb_gpio_ext #(.APB_ADDR_WIDTH(12), .NUM_GPIO(NG), .DEBOUNCE_W(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
        .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
        .interrupt(interrupt)
    );

    always #5 HCLK = ~HCLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        cyc(1);
        PENABLE = 1'b1;
        cyc(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        cyc(1);
        PENABLE = 1'b1;
        #1;
        d = PRDATA;
        e = PSLVERR;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; gpio_in = '0;
        PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        cyc(3);
        HRESETn = 1'b1;
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", interrupt); end
        total++; if (gpio_dir !== 8'h00) begin bad++; $display("FAIL rst_dir got=%h exp=00", gpio_dir); end
        total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL rst_out got=%h exp=00", gpio_out); end
        total++; if (gpio_in_sync !== 8'h00) begin bad++; $display("FAIL rst_insync got=%h exp=00", gpio_in_sync); end
        total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL pready got=%b exp=1", PREADY); end
        for (int a = 0; a <= 'h24; a += 4) begin
            apb_read(12'(a), rd, er);
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_rd_%h got=%h exp=0", a, rd); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL rst_err_%h got=%b exp=0", a, er); end
        end
        apb_write(12'h028, 32'hFFFF_FFFF);
        apb_read(12'h028, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", rd); end
        total++; if (er !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b exp=1", er); end
        apb_read(12'h03C, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL unmapped3c_err got=%b exp=1", er); end
        PADDR = 12'h028; #1;
        total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL idle_err got=%b exp=0", PSLVERR); end
        cyc(1);
    endtask

    task automatic test_out();
        apb_write(12'h008, 32'h0000_00F0);
        apb_write(12'h00C, 32'h0000_0003);
        apb_write(12'h010, 32'h0000_0030);
        apb_read(12'h008, rd, er);
        total++; if (rd !== 32'h0000_00C3) begin bad++; $display("FAIL out_rd got=%h exp=000000c3", rd); end
        total++; if (gpio_out !== 8'hC3) begin bad++; $display("FAIL out_pin got=%h exp=c3", gpio_out); end
        apb_read(12'h00C, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL outset_rd got=%h exp=0", rd); end
        apb_read(12'h010, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL outclr_rd got=%h exp=0", rd); end
        apb_write(12'h008, 32'hFFFF_FFFF);
        apb_read(12'h008, rd, er);
        total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL out_mask got=%h exp=000000ff", rd); end
    endtask

    task automatic test_debounce_rise();
        apb_write(12'h024, 32'h3);
        apb_read(12'h024, rd, er);
`ifdef GPIO_DEBOUNCE_EN
        total++; if (rd !== 32'h3) begin bad++; $display("FAIL deb_rd got=%h exp=3", rd); end
`else
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL deb_rd got=%h exp=0", rd); end
`endif
        total++; if (er !== 1'b0) begin bad++; $display("FAIL deb_err got=%b exp=0", er); end
        apb_write(12'h018, 32'h0);
        apb_write(12'h01C, 32'h0);
        apb_write(12'h014, 32'h20);
`ifdef GPIO_DEBOUNCE_EN
        gpio_in[5] = 1'b1;
        cyc(3);
        gpio_in[5] = 1'b0;
        cyc(8);
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL pulse_irq got=%b exp=0", interrupt); end
        apb_read(12'h004, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL pulse_in got=%h exp=0", rd); end
`endif
        gpio_in[5] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            cyc(1);
            if (k == LAT - 2) begin
                total++; if (gpio_in_sync[5] !== 1'b0) begin bad++; $display("FAIL lat_sync_early got=%b exp=0", gpio_in_sync[5]); end
            end
            if (k == LAT - 1) begin
                total++; if (gpio_in_sync[5] !== 1'b1) begin bad++; $display("FAIL lat_sync got=%b exp=1", gpio_in_sync[5]); end
                total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL lat_irq_early got=%b exp=0", interrupt); end
            end
            if (k == LAT) begin
                total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL lat_irq got=%b exp=1", interrupt); end
            end
        end
        cyc(5);
        apb_read(12'h004, rd, er);
        total++; if (rd !== 32'h20) begin bad++; $display("FAIL rise_in got=%h exp=20", rd); end
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h20) begin bad++; $display("FAIL rise_stat got=%h exp=20", rd); end
        apb_write(12'h014, 32'h0);
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL masked_irq got=%b exp=0", interrupt); end
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h20) begin bad++; $display("FAIL masked_stat got=%h exp=20", rd); end
        apb_write(12'h020, 32'h20);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_rise got=%h exp=0", rd); end
        gpio_in[5] = 1'b0;
        cyc(10);
        apb_write(12'h024, 32'h0);
    endtask

    task automatic test_any_edge();
        apb_write(12'h01C, 32'h04);
        apb_write(12'h018, 32'h00);
        apb_write(12'h014, 32'h04);
        gpio_in[2] = 1'b1;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL any_rise got=%h exp=4", rd); end
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL any_irq got=%b exp=1", interrupt); end
        apb_write(12'h020, 32'h4);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL any_clr got=%h exp=0", rd); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL any_clr_irq got=%b exp=0", interrupt); end
        gpio_in[2] = 1'b0;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL any_fall got=%h exp=4", rd); end
        apb_write(12'h020, 32'h4);
        apb_write(12'h014, 32'h0);
    endtask

    task automatic test_falling();
        apb_write(12'h018, 32'h08);
        apb_write(12'h01C, 32'h00);
        apb_write(12'h014, 32'h08);
        gpio_in[3] = 1'b1;
        gpio_in[6] = 1'b1;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL fall_on_rise got=%h exp=0", rd); end
        gpio_in[3] = 1'b0;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL fall_set got=%h exp=8", rd); end
        apb_write(12'h014, 32'h48);
        cyc(3);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL fall_no_late got=%h exp=8", rd); end
        apb_write(12'h020, 32'h8);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL fall_clr got=%h exp=0", rd); end
        apb_write(12'h014, 32'h0);
        gpio_in[6] = 1'b0;
        cyc(6);
    endtask

    task automatic test_level();
        apb_write(12'h018, 32'h01);
        apb_write(12'h01C, 32'h01);
        apb_write(12'h014, 32'h01);
        gpio_in[0] = 1'b1;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL lvl_set got=%h exp=1", rd); end
        apb_write(12'h020, 32'h1);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL lvl_set_wins got=%h exp=1", rd); end
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL lvl_irq got=%b exp=1", interrupt); end
        gpio_in[0] = 1'b0;
        cyc(6);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL lvl_sticky got=%h exp=1", rd); end
        apb_write(12'h020, 32'h1);
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL lvl_clr got=%h exp=0", rd); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL lvl_irq_fall got=%b exp=0", interrupt); end
        apb_write(12'h014, 32'h0);
    endtask

    task automatic test_dir_and_reset();
        apb_write(12'h000, 32'hFFFF_FFFF);
        apb_read(12'h000, rd, er);
        total++; if (rd !== 32'h0000_00FF) begin bad++; $display("FAIL dir_mask got=%h exp=000000ff", rd); end
        total++; if (gpio_dir !== 8'hFF) begin bad++; $display("FAIL dir_pin got=%h exp=ff", gpio_dir); end
        apb_write(12'h018, 32'h80);
        apb_write(12'h01C, 32'h80);
        apb_write(12'h014, 32'h80);
        gpio_in[7] = 1'b1;
        cyc(8);
        total++; if (interrupt !== 1'b1) begin bad++; $display("FAIL pre_rst_irq got=%b exp=1", interrupt); end
        apb_write(12'h024, 32'h5);
        apb_write(12'h008, 32'h5A);
        gpio_in[4] = 1'b1;
        cyc(3);
        HRESETn = 1'b0;
        gpio_in = '0;
        cyc(1);
        HRESETn = 1'b1;
        total++; if (gpio_out !== 8'h00) begin bad++; $display("FAIL mrst_out got=%h exp=00", gpio_out); end
        total++; if (gpio_dir !== 8'h00) begin bad++; $display("FAIL mrst_dir got=%h exp=00", gpio_dir); end
        total++; if (gpio_in_sync !== 8'h00) begin bad++; $display("FAIL mrst_insync got=%h exp=00", gpio_in_sync); end
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL mrst_irq got=%b exp=0", interrupt); end
        apb_read(12'h020, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mrst_stat got=%h exp=0", rd); end
        apb_read(12'h024, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mrst_deb got=%h exp=0", rd); end
        apb_read(12'h014, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mrst_inten got=%h exp=0", rd); end
        apb_read(12'h01C, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mrst_type1 got=%h exp=0", rd); end
        apb_read(12'h004, rd, er);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mrst_in got=%h exp=0", rd); end
        cyc(6);
        total++; if (interrupt !== 1'b0) begin bad++; $display("FAIL mrst_spurious got=%b exp=0", interrupt); end
    endtask

    initial begin
        test_reset();
        test_out();
        test_debounce_rise();
        test_any_edge();
        test_falling();
        test_level();
        test_dir_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_gpio_ext.md
Name: apb_gpio_ext

Overview:
Parametrised APB GPIO controller and successor to the fixed 32-pin GPIO. Adds configurable pin count, per-pin input debounce, atomic output set/clear registers, a both-edge interrupt mode, and a sticky write-1-to-clear interrupt status. Sits on the peripheral APB bus as a 4 KB slave; its interrupt line feeds the event/interrupt controller.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; only PADDR[5:2] is decoded
NUM_GPIO, 32, pin count, legal range 1..32; register bits [31:NUM_GPIO] read 0 and ignore writes
DEBOUNCE_W, 8, width of the debounce threshold and of each per-pin counter

Ports:
HCLK  in  1  clock; all logic on posedge
HRESETn  in  1  synchronous active-low reset
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  APB write data
PWRITE  in  1  APB write
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data, combinational from the address
PREADY  out  1  tied to 1; zero wait states
PSLVERR  out  1  error on unmapped address
gpio_in  in  NUM_GPIO  raw pad inputs
gpio_in_sync  out  NUM_GPIO  filtered input value (see debounce below)
gpio_out  out  NUM_GPIO  output register
gpio_dir  out  NUM_GPIO  direction; 1 = output
interrupt  out  1  level interrupt

Behaviour:
- Clock is HCLK. Reset HRESETn is synchronous and active-low: it is sampled only on the HCLK rising edge. At reset every register, synchroniser, filter and counter is 0, so gpio_out=0, gpio_dir=0, gpio_in_sync=0 and interrupt=0.
- A write commits on a cycle with PSEL&PENABLE&PWRITE. Reads have no side effects.
- Register map, offset selected by PADDR[5:2]:
  - 0x00 DIR: RW.
  - 0x04 IN: RO, returns the filtered value.
  - 0x08 OUT: RW.
  - 0x0C OUTSET: WO, sets OUT bits where the write data is 1.
  - 0x10 OUTCLR: WO, clears OUT bits where the write data is 1.
  - 0x14 INTEN: RW.
  - 0x18 INTTYPE0: RW.
  - 0x1C INTTYPE1: RW.
  - 0x20 INTSTATUS: RW1C.
  - 0x24 DEBOUNCE: RW, bits [DEBOUNCE_W-1:0].
  - OUTSET and OUTCLR read 0.
- Unmapped offsets 0x28-0x3C: PRDATA=0, writes ignored, PSLVERR=1 while PSEL&PENABLE. PSLVERR=0 otherwise.
- Input path: two-flop synchroniser (sync1) -> debounce filter (filt) -> a delayed copy (filt_d) used for edge detection. gpio_in_sync=filt.
- Debounce, per pin, with D=DEBOUNCE:
  - If sync1==filt: cnt<=0.
  - Else if cnt==D: filt<=sync1 and cnt<=0.
  - Else: cnt<=cnt+1.
  - A change is therefore accepted after D+1 consecutive differing samples. D=0 gives no filtering beyond one cycle.
  - Writing DEBOUNCE mid-count does not reset the counters; the new D applies from the next cycle.
- Interrupt type per pin, as {INTTYPE1,INTTYPE0}:
  - 00: rising edge (filt & ~filt_d).
  - 01: falling edge.
  - 10: any edge.
  - 11: level high (filt).
- Status bit i is set on the cycle after its condition is true and INTEN[i]=1. Disabled pins never set status, but bits already set stay set.
- A W1C write clears the bits written as 1. If set and clear hit the same bit in the same cycle, set wins, so a level-high pin cannot be cleared while it is still high.
- interrupt = |(INTSTATUS & INTEN), combinational from registers. Latency from a gpio_in edge to interrupt is 3+(D+1) cycles with debounce on, or 3 cycles with it off.
- OUT write priority within a cycle: only one register is addressed per cycle, so there is no conflict between OUT, OUTSET and OUTCLR.
- Reset mid-operation clears status, counters and filters. No spurious edge is detected afterwards because filt and filt_d are both 0.

Optional Feature:
GPIO_DEBOUNCE_EN.
- Defined: the debounce filter and DEBOUNCE register are implemented as described above.
- Undefined: filt=sync1 directly, no counters are instantiated, DEBOUNCE reads 0 and ignores writes, and the offset remains mapped (PSLVERR=0).

Test Plan:
1. Reset, then read all mapped registers -> all read 0, interrupt=0, gpio_dir=0. Read 0x28 -> PRDATA=0, PSLVERR=1.
2. Write OUT=0x0000_00F0, OUTSET=0x0000_0003, OUTCLR=0x0000_0030 -> OUT reads 0x0000_00C3, gpio_out matches; OUTSET reads 0.
3. DEBOUNCE=3, INTEN[5]=1, type 00; gpio_in[5] pulses high for 3 cycles -> no change in IN and interrupt stays 0. Held high for 10 cycles -> IN[5]=1, INTSTATUS=0x20 and interrupt=1 exactly 7 cycles after the input rises.
4. Type 10 on pin 2 with D=0; toggle pin 2 high then low -> status set after each edge. W1C 0x4 between the edges clears it; the second edge sets it again.
5. Type 11 on pin 0, input held high, write INTSTATUS=0x1 -> bit stays 1 (set wins). Drop the input, then W1C -> bit becomes 0 and interrupt falls.
6. NUM_GPIO=8: write DIR=0xFFFF_FFFF -> DIR reads 0x0000_00FF. Assert HRESETn=0 for one cycle mid-debounce -> all state returns to 0 on the next edge.
